// File: rtl/pwm_capture_if.sv
// Bundles the PWM line and the measurement results of pwm_capture.
// master: the side that drives the PWM line and reads back results.
// slave:  the capture block itself.
interface pwm_capture_if #(
  parameter int CNT_W = 16,
  parameter int OUT_W = 4
);
  logic             pwm_in;
  logic [OUT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stuck;

  modport master (
    output pwm_in,
    input  duty,
    input  period,
    input  valid,
    input  stuck
  );

  modport slave (
    input  pwm_in,
    output duty,
    output period,
    output valid,
    output stuck
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes a PWM line, measures high time and period
// between consecutive rising edges and converts the ratio into an OUT_W-bit
// duty code with a restoring shift-subtract divider. A line with no rising
// edge for TIMEOUT_CYC cycles is reported as stuck.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int OUT_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic          clk,
  input logic          rst,
  pwm_capture_if.slave cap
);

  localparam int             IT_W     = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(OUT_W + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_HOLD  = CNT_W'(TIMEOUT_CYC);
  localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(OUT_W - 1);
  localparam logic [IT_W-1:0]  IT_ONE   = IT_W'(1);
  localparam logic [OUT_W-1:0] DUTY_MAX = {OUT_W{1'b1}};

  typedef enum logic [0:0] {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  // Input synchronizer and edge-detect copy
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_s;

  // Measurement FSM and counters
  state_t           state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             load_s;
  logic             timeout_s;

  // Divider
  logic             div_run_q, div_run_d;
  logic             div_done_q, div_done_d;
  logic             div_sat_q, div_sat_d;
  logic [IT_W-1:0]  div_it_q, div_it_d;
  logic [CNT_W:0]   div_rem_q, div_rem_d;
  logic [CNT_W-1:0] div_per_q, div_per_d;
  logic [OUT_W-1:0] div_quo_q, div_quo_d;
  logic [CNT_W:0]   rem_sh_s;

  // Registered outputs
  logic [OUT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] per_out_q, per_out_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;

  assign rise_s = sync2_q & ~prev_q;

  // Bring the asynchronous line into the clock domain and keep a delayed copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= cap.pwm_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next state of the measurement FSM, edge counters and idle timeout
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    stuck_d      = stuck_q;
    load_s       = 1'b0;
    timeout_s    = 1'b0;

    // A rising edge in the same cycle as the timeout wins; once stuck the
    // idle counter parks at TIMEOUT_CYC so the timeout cannot fire again.
    if (rise_s) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TO_LAST) begin
      timeout_s  = 1'b1;
      idle_cnt_d = TO_HOLD;
    end else if (idle_cnt_q != TO_HOLD) begin
      idle_cnt_d = idle_cnt_q + CNT_ONE;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    case (state_q)
      WAIT_EDGE: begin
        if (rise_s) begin
          // The edge cycle is already cycle 1 of the first period, so the
          // first reported period uses the same counting as later ones.
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          stuck_d      = 1'b0;
          state_d      = MEASURE;
        end else begin
          state_d = WAIT_EDGE;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          // Periods too short to resolve, or a divider still working on the
          // previous period, drop this snapshot; counting restarts anyway.
          load_s       = (period_cnt_q >= MIN_PER) && !div_run_q;
          period_cnt_d = CNT_ONE;
          high_cnt_d   = CNT_ONE;
          state_d      = MEASURE;
        end else if (timeout_s) begin
          state_d = WAIT_EDGE;
        end else begin
          if (period_cnt_q != CNT_MAX) begin
            period_cnt_d = period_cnt_q + CNT_ONE;
          end else begin
            period_cnt_d = period_cnt_q;
          end
          if (sync2_q && (high_cnt_q != CNT_MAX)) begin
            high_cnt_d = high_cnt_q + CNT_ONE;
          end else begin
            high_cnt_d = high_cnt_q;
          end
          state_d = MEASURE;
        end
      end
      default: begin
        state_d = WAIT_EDGE;
      end
    endcase

    if (timeout_s) begin
      stuck_d = 1'b1;
      state_d = WAIT_EDGE;
    end else begin
      stuck_d = stuck_d;
    end
  end

  assign rem_sh_s = {div_rem_q[CNT_W-1:0], 1'b0};

  // Restoring divider: one quotient bit per cycle, OUT_W iterations
  always_comb begin
    div_run_d  = div_run_q;
    div_done_d = 1'b0;
    div_sat_d  = div_sat_q;
    div_it_d   = div_it_q;
    div_rem_d  = div_rem_q;
    div_per_d  = div_per_q;
    div_quo_d  = div_quo_q;

    if (timeout_s) begin
      // A timeout supersedes any division in flight.
      div_run_d  = 1'b0;
      div_done_d = 1'b0;
    end else if (load_s) begin
      div_run_d  = 1'b1;
      div_it_d   = '0;
      div_rem_d  = {1'b0, high_cnt_q};
      div_per_d  = period_cnt_q;
      div_quo_d  = '0;
      div_sat_d  = (high_cnt_q >= period_cnt_q);
    end else if (div_run_q) begin
      if (rem_sh_s >= {1'b0, div_per_q}) begin
        div_rem_d = rem_sh_s - {1'b0, div_per_q};
        div_quo_d = {div_quo_q[OUT_W-2:0], 1'b1};
      end else begin
        div_rem_d = rem_sh_s;
        div_quo_d = {div_quo_q[OUT_W-2:0], 1'b0};
      end
      if (div_it_q == IT_LAST) begin
        div_run_d  = 1'b0;
        div_done_d = 1'b1;
      end else begin
        div_it_d = div_it_q + IT_ONE;
      end
    end else begin
      div_run_d = 1'b0;
    end
  end

  // Output update: timeout result has priority over a completing division
  always_comb begin
    duty_d    = duty_q;
    per_out_d = per_out_q;
    valid_d   = 1'b0;

    if (timeout_s) begin
      duty_d    = sync2_q ? DUTY_MAX : {OUT_W{1'b0}};
      per_out_d = '0;
      valid_d   = 1'b1;
    end else if (div_done_q) begin
      duty_d    = div_sat_q ? DUTY_MAX : div_quo_q;
      per_out_d = div_per_q;
      valid_d   = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State, counter, divider and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_EDGE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      div_run_q    <= 1'b0;
      div_done_q   <= 1'b0;
      div_sat_q    <= 1'b0;
      div_it_q     <= '0;
      div_rem_q    <= '0;
      div_per_q    <= '0;
      div_quo_q    <= '0;
      duty_q       <= '0;
      per_out_q    <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      div_run_q    <= div_run_d;
      div_done_q   <= div_done_d;
      div_sat_q    <= div_sat_d;
      div_it_q     <= div_it_d;
      div_rem_q    <= div_rem_d;
      div_per_q    <= div_per_d;
      div_quo_q    <= div_quo_d;
      duty_q       <= duty_d;
      per_out_q    <= per_out_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
    end
  end

  assign cap.duty   = duty_q;
  assign cap.period = per_out_q;
  assign cap.valid  = valid_q;
  assign cap.stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: drives PWM patterns and random lines and checks
// every cycle against a period/edge-level model of the measurement rules.
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int OUT_W       = 4;
  localparam int TIMEOUT_CYC = 1024;
  localparam int DMAX        = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pwm_capture_if #(.CNT_W(CNT_W), .OUT_W(OUT_W)) cap_if ();

  pwm_capture #(.CNT_W(CNT_W), .OUT_W(OUT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .cap (cap_if)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the line is seen two cycles late; periods are measured
  // between rising edges of that delayed line, results appear OUT_W+1 cycles
  // after the closing edge, and TIMEOUT_CYC edge-free cycles mean stuck.
  typedef struct {
    int edge_n;
    int duty;
    int per;
  } pend_t;

  pend_t pq[$];
  int    n, last, ones;
  bit    tracking, m_stuck;
  bit    h1, h2, h3;
  int    m_duty, m_per;
  int    model_valids = 0;
  int    dut_valids   = 0;

  task automatic model_reset();
    n        = 0;
    last     = 0;
    ones     = 0;
    tracking = 1'b0;
    m_stuck  = 1'b0;
    h1       = 1'b0;
    h2       = 1'b0;
    h3       = 1'b0;
    m_duty   = 0;
    m_per    = 0;
    pq.delete();
  endtask

  task automatic tick(input bit v);
    bit    s, p, rise, to, mv;
    int    per, d;
    pend_t e;
    cap_if.pwm_in = v;
    @(posedge clk);
    n++;
    s  = h2;
    p  = h3;
    h3 = h2;
    h2 = h1;
    h1 = v;
    rise = s && !p;
    to   = 1'b0;
    mv   = 1'b0;
    if (rise) begin
      if (tracking) begin
        per = n - last;
        if (per >= OUT_W + 1) begin
          d = (ones * (1 << OUT_W)) / per;
          if (d > DMAX) d = DMAX;
          pq.push_back('{n + OUT_W + 1, d, per});
        end
      end
      tracking = 1'b1;
      m_stuck  = 1'b0;
      last     = n;
      ones     = 1;
    end else begin
      if (s) ones++;
      if (!m_stuck && ((n - last) == TIMEOUT_CYC)) begin
        to = 1'b1;
        pq.delete();
        m_duty   = s ? DMAX : 0;
        m_per    = 0;
        m_stuck  = 1'b1;
        tracking = 1'b0;
        mv       = 1'b1;
      end
    end
    if (!to && (pq.size() > 0) && (pq[0].edge_n == n)) begin
      e      = pq.pop_front();
      m_duty = e.duty;
      m_per  = e.per;
      mv     = 1'b1;
    end
    #1;
    chk("valid", cap_if.valid, mv);
    chk("duty", cap_if.duty, m_duty);
    chk("period", cap_if.period, m_per);
    chk("stuck", cap_if.stuck, m_stuck);
    if (mv) model_valids++;
    if (cap_if.valid) dut_valids++;
  endtask

  task automatic pwm_period(input int hi, input int per);
    repeat (hi) tick(1'b1);
    repeat (per - hi) tick(1'b0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b0;
    #1;
    chk("rst_duty", cap_if.duty, 0);
    chk("rst_period", cap_if.period, 0);
    chk("rst_valid", cap_if.valid, 0);
    chk("rst_stuck", cap_if.stuck, 0);
    repeat (cyc) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Stimulus sequence
  initial begin
    int per, hi;
    cap_if.pwm_in = 1'b0;
    model_reset();
    #2;
    do_reset(3);

    // Line held low from reset: a single timeout with duty 0
    repeat (1100) tick(1'b0);

    // 40 high / 120 low, then held high into a timeout, then recovery
    repeat (4) pwm_period(40, 160);
    repeat (1100) tick(1'b1);
    repeat (4) pwm_period(40, 160);

    // Generator-style 16-cycle period, code 5 then sweep 1..15
    repeat (6) pwm_period(5, 16);
    for (int a = 1; a <= 15; a++) begin
      repeat (3) pwm_period(a, 16);
    end

    // Period 3: always discarded, never times out
    repeat (150) pwm_period(1, 3);

    // Reset two cycles into a division
    repeat (3) pwm_period(5, 16);
    repeat (5) tick(1'b1);
    do_reset(2);
    repeat (5) pwm_period(5, 16);

    // Random periods and duties, including short ones
    repeat (60) begin
      per = $urandom_range(80, 3);
      hi  = $urandom_range(per - 1, 1);
      repeat ($urandom_range(3, 1)) pwm_period(hi, per);
    end

    // Random per-cycle noise
    repeat (300) tick(1'($urandom_range(1, 0)));
    repeat (40) tick(1'b0);

    chk("valid_count", dut_valids, model_valids);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
